// File: rtl/mem_ops_pkg.sv
// Shared definitions for the memory-side store path.
//   SZ_*           : store size encodings carried on req_size.
//   state_t        : sequencing states of the store read-modify-write unit.
//   is_misaligned  : flags illegal sizes and addresses that are not aligned to the access size.
package mem_ops_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WAIT,
    ST_WRITE,
    ST_ERR
  } state_t;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic r_bad;
    r_bad = 1'b1;
    case (size)
      SZ_BYTE: r_bad = 1'b0;
      SZ_HALF: r_bad = addr_lo[0];
      SZ_WORD: r_bad = (addr_lo != 2'b00);
      default: r_bad = 1'b1;
    endcase
    return r_bad;
  endfunction

endpackage

// File: rtl/store_lane_merge.sv
// Combinational lane merge for sub-word stores into a 32-bit little-endian word.
//   i_old_word : word currently held in memory
//   i_data     : register value; low byte / half used for byte / half stores
//   i_size     : SZ_BYTE, SZ_HALF, SZ_WORD (SZ_ILL leaves the word unchanged)
//   i_addr_lo  : byte address bits [1:0] selecting the lane
//   o_new_word : old word with the target lane(s) replaced
module store_lane_merge
  import mem_ops_pkg::*;
(
  input  logic [31:0] i_old_word,
  input  logic [31:0] i_data,
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_addr_lo,
  output logic [31:0] o_new_word
);

  // Replicate the source across lanes so every lane can pick its byte from
  // the same bit positions; the per-lane enable then decides who takes it.
  logic [31:0] w_src;

  always_comb begin
    w_src = i_data;
    case (i_size)
      SZ_BYTE: w_src = {4{i_data[7:0]}};
      SZ_HALF: w_src = {2{i_data[15:0]}};
      default: w_src = i_data;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      logic w_sel;

      always_comb begin
        w_sel = 1'b0;
        case (i_size)
          SZ_BYTE: w_sel = (i_addr_lo == LANE);
          SZ_HALF: w_sel = (i_addr_lo[1] == LANE[1]);
          SZ_WORD: w_sel = 1'b1;
          default: w_sel = 1'b0;
        endcase
      end

      assign o_new_word[8*gi +: 8] = w_sel ? w_src[8*gi +: 8] : i_old_word[8*gi +: 8];
    end
  endgenerate

endmodule

// File: rtl/store_rmw_unit.sv
// MEM-stage store unit for a word-only data memory. Word stores write directly;
// byte and half stores read the word, merge the lane and write it back.
//   clk, reset_n            : clock, synchronous active-low reset
//   req_valid/ready         : store request handshake (addr, data, size)
//   mem_addr                : word address of the current sequence
//   mem_rd_en / mem_rdata   : read strobe, read data RD_LAT cycles later
//   mem_wr_en / mem_wdata   : write strobe and merged word
//   busy, done, misalign    : pipeline stall, completion pulse, error pulse
module store_rmw_unit
  import mem_ops_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_data,
  input  logic [1:0]        req_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [31:0]       mem_rdata,
  output logic              mem_wr_en,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              misalign
);

  state_t            r_state;
  state_t            w_next_state;
  state_t            w_accept_state;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_data;
  logic [1:0]        r_size;
  logic [31:0]       r_rdata;
  logic              r_wait_cnt;   // RD_LAT is at most 2, so one bit counts the WAIT cycles
  logic              w_wait_last;
  logic              w_accept;
  logic [31:0]       w_merged;

  assign w_wait_last = (r_wait_cnt == 1'(RD_LAT - 1));
  assign w_accept    = req_valid & req_ready;

  always_comb begin
    if (is_misaligned(req_size, req_addr[1:0])) begin
      w_accept_state = ST_ERR;
    end else if (req_size == SZ_WORD) begin
      w_accept_state = ST_WRITE;
    end else begin
      w_accept_state = ST_READ;
    end
  end

  // WRITE and ERR are terminal one-cycle states; they advertise ready so a
  // waiting request is taken on their exit edge with no idle bubble.
  always_comb begin
    w_next_state = r_state;
    req_ready    = 1'b0;
    mem_rd_en    = 1'b0;
    mem_wr_en    = 1'b0;
    done         = 1'b0;
    misalign     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
      end
      ST_READ: begin
        mem_rd_en    = 1'b1;
        w_next_state = ST_WAIT;
      end
      ST_WAIT: begin
        if (w_wait_last) begin
          w_next_state = ST_WRITE;
        end
      end
      ST_WRITE: begin
        mem_wr_en    = 1'b1;
        done         = 1'b1;
        req_ready    = 1'b1;
        w_next_state = ST_IDLE;
      end
      ST_ERR: begin
        misalign     = 1'b1;
        req_ready    = 1'b1;
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
    if (w_accept) begin
      w_next_state = w_accept_state;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_addr     <= '0;
      r_data     <= '0;
      r_size     <= '0;
      r_rdata    <= '0;
      r_wait_cnt <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_addr <= req_addr;
        r_data <= req_data;
        r_size <= req_size;
      end
      if (r_state == ST_READ) begin
        r_wait_cnt <= 1'b0;
      end else if (r_state == ST_WAIT) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end
      if ((r_state == ST_WAIT) && w_wait_last) begin
        r_rdata <= mem_rdata;
      end
    end
  end

  store_lane_merge u_merge (
    .i_old_word (r_rdata),
    .i_data     (r_data),
    .i_size     (r_size),
    .i_addr_lo  (r_addr[1:0]),
    .o_new_word (w_merged)
  );

  assign mem_addr  = {r_addr[ADDR_W-1:2], 2'b00};
  assign mem_wdata = w_merged;
  assign busy      = (r_state != ST_IDLE);

endmodule
